imoy_sched: RTL and testbench
=============================

IMOY_SCHED -- requirements
Module: imoy_sched

Interface
REQ-001 Parameter DW_IN, default 10, pixel data width of each of the four window samples.
REQ-002 Parameter NREQ, default 4, number of requesters sharing one 4-sample averager; legal range 2..8.
REQ-003 Parameter IDW, default 3, width of requester ID; SHALL satisfy 2^IDW >= NREQ.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sched_en  input  1  scheduler enable; low blocks new grants, in-flight results still retire.
REQ-007 req_valid  input  NREQ  per-requester window-valid.
REQ-008 req_data  input  NREQ*4*DW_IN  per-requester 2x2 window; requester k occupies slice [k*4*DW_IN +: 4*DW_IN].
REQ-009 req_ready  output  NREQ  one-hot-or-zero accept strobe, combinational from req_valid, sched_en, pointer.
REQ-010 avg_calc_en  output  1  drives averager enable; equals transfer this cycle.
REQ-011 avg_imcin  output  4*DW_IN  window of granted requester, zero when no transfer.
REQ-012 avg_imoy  input  DW_IN  averager result, registered, valid 2 cycles after its enable.
REQ-013 out_valid  output  1  one-cycle result strobe.
REQ-014 out_id  output  IDW  requester ID of result.
REQ-015 out_data  output  DW_IN  rounded average, captured copy of avg_imoy.
REQ-016 busy  output  1  high while any issued window has not yet produced out_valid.

Function
REQ-017 Transfer for requester k SHALL occur in a cycle iff req_valid[k] && req_ready[k]; at most one transfer per cycle.
REQ-018 Arbitration SHALL be round-robin: search starts at pointer p, first k in order p, p+1, ..., wrapping modulo NREQ, with req_valid[k]=1 wins.
REQ-019 On transfer by k, pointer SHALL update to (k+1) mod NREQ next cycle; no transfer leaves pointer unchanged.
REQ-020 With sched_en=0, req_ready SHALL be all zero and avg_calc_en 0.
REQ-021 A 2-stage tag pipeline (valid bit + ID) SHALL shift every cycle; stage0 loads {transfer, winner ID}.
REQ-022 Latency: transfer at cycle t -> out_valid=1 at cycle t+3, out_data = avg_imoy sampled at t+2 edge, out_id = winner ID.
REQ-023 out_data/out_id SHALL hold last value when out_valid=0.
REQ-024 Back-to-back transfers every cycle SHALL be supported; throughput one window per clock, no output backpressure.
REQ-025 busy = OR of tag stage valids and out_valid pending; SHALL fall the cycle after last out_valid.
REQ-026 sched_en dropping mid-flight SHALL NOT cancel issued windows; they retire at normal latency.
REQ-027 Single requester continuously valid SHALL be granted every cycle.

Reset
REQ-028 Reset SHALL clear pointer to 0, tag pipeline valids and IDs to 0, out_valid 0, out_id 0, out_data 0, busy 0.
REQ-029 Reset assertion mid-operation SHALL discard in-flight windows; no out_valid after deassertion for them.

Configuration
REQ-030 Macro IMOY_SCHED_PRIO0_EN: defined -> requester 0 wins whenever req_valid[0]=1, others round-robin among themselves (pointer skips 0); undefined -> pure round-robin per REQ-018.

Verification
REQ-031 All NREQ=4 valid continuously from p=0 -> grants 0,1,2,3,0 on consecutive cycles; out_id 0,1,2,3 at t+3..t+6.
REQ-032 Requester 2 only, window {1023,1023,1023,1023}, model avg returns 1023 -> out_valid at t+3, out_data 1023, out_id 2.
REQ-033 Requesters 1 and 3 valid, pointer=2 -> grant 3 first, then 1; pointer ends at 2.
REQ-034 Two transfers then sched_en=0 -> req_ready 0, both results retire at t+3, t+4; busy low at t+5.
REQ-035 rst_n pulsed one cycle after a transfer -> no out_valid afterwards, all outputs 0, pointer 0.
REQ-036 IMOY_SCHED_PRIO0_EN defined, requesters 0 and 1 continuously valid -> requester 0 granted every cycle; release 0 -> 1 granted next cycle.

Source files
------------

// File: rtl/imoy_sched.sv
// -----------------------------------------------------------------------------
// imoy_sched
//   Round-robin scheduler that lets NREQ requesters share one external 4-sample
//   (2x2 window) averager. A granted window is forwarded to the averager for
//   one cycle. A 2-stage tag pipeline tracks the requester ID alongside the
//   averager latency, so each result is returned with its ID three cycles
//   after the grant.
//
//   Optional feature (compile-time macro IMOY_SCHED_PRIO0_EN):
//     defined   -> requester 0 has strict priority. The remaining requesters
//                  round-robin among themselves, and the pointer never rests
//                  on 0.
//     undefined -> pure round-robin over all requesters.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   sched_en     scheduler enable; low blocks new grants only
//   req_valid    per-requester window-valid            [NREQ]
//   req_data     per-requester 2x2 windows             [NREQ*4*DW_IN]
//   req_ready    one-hot-or-zero accept strobe         [NREQ]
//   avg_calc_en  averager enable (transfer this cycle)
//   avg_imcin    window of the granted requester, zero when idle
//   avg_imoy     averager result, valid 2 cycles after its enable
//   out_valid    one-cycle result strobe
//   out_id       requester ID of the result            [IDW]
//   out_data     captured averager result              [DW_IN]
//   busy         a window is still in flight or retiring
// -----------------------------------------------------------------------------
module imoy_sched #(
    parameter int unsigned DW_IN = 10,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sched_en,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*4*DW_IN-1:0] req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    avg_calc_en,
    output logic [4*DW_IN-1:0]      avg_imcin,
    input  logic [DW_IN-1:0]        avg_imoy,
    output logic                    out_valid,
    output logic [IDW-1:0]          out_id,
    output logic [DW_IN-1:0]        out_data,
    output logic                    busy
);

`ifdef IMOY_SCHED_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    // Reduce an index in [0, 2*NREQ) to [0, NREQ). This avoids a general
    // modulo, which matters when NREQ is not a power of two.
    function automatic int unsigned wrap(input int unsigned a);
        return (a >= NREQ) ? a - NREQ : a;
    endfunction

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] win;
    logic           found;
    logic           transfer;

    logic           s0_v;
    logic [IDW-1:0] s0_id;
    logic           s1_v;
    logic [IDW-1:0] s1_id;

    // Winner search: the first valid requester, starting at the pointer and
    // wrapping. In priority mode, requester 0 is resolved before the loop and
    // is excluded from the circular search.
    always_comb begin
        found = 1'b0;
        win   = '0;
        if (PRIO0 && req_valid[0]) begin
            found = 1'b1;
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_valid[wrap(32'(ptr) + i)] &&
                !(PRIO0 && wrap(32'(ptr) + i) == 0)) begin
                found = 1'b1;
                win   = IDW'(wrap(32'(ptr) + i));
            end
        end
    end

    always_comb begin
        transfer    = sched_en && found;
        avg_calc_en = transfer;
        req_ready   = transfer ? (NREQ'(1) << win) : '0;
        avg_imcin   = transfer ? req_data[32'(win)*4*DW_IN +: 4*DW_IN] : '0;
    end

    // Pointer advances past the winner. A priority grant to requester 0 leaves
    // the round-robin position of the other requesters untouched.
    always_comb begin
        ptr_nxt = ptr;
        if (transfer && !(PRIO0 && win == '0)) begin
            ptr_nxt = IDW'(wrap(32'(win) + 1));
            if (PRIO0 && ptr_nxt == '0) begin
                ptr_nxt = IDW'(1);
            end
        end
    end

    // The tag stages match the 2-cycle averager latency. The output register
    // adds the third cycle and holds its value between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            s0_v      <= 1'b0;
            s0_id     <= '0;
            s1_v      <= 1'b0;
            s1_id     <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_data  <= '0;
        end else begin
            ptr       <= ptr_nxt;
            s0_v      <= transfer;
            s0_id     <= win;
            s1_v      <= s0_v;
            s1_id     <= s0_id;
            out_valid <= s1_v;
            if (s1_v) begin
                out_id   <= s1_id;
                out_data <= avg_imoy;
            end
        end
    end

    assign busy = s0_v | s1_v | out_valid;

endmodule

// File: tb/tb_imoy_sched.sv
// -----------------------------------------------------------------------------
// tb_imoy_sched
//   Directed bench for imoy_sched with DW_IN=10, NREQ=4, IDW=3. A behavioural
//   averager (two register stages, round-to-nearest mean) stands in for the
//   external block. Expected grants, IDs and averages are hand-computed.
//   Build with IMOY_SCHED_PRIO0_EN defined to exercise the priority variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imoy_sched;

    localparam int unsigned DW   = 10;
    localparam int unsigned NR   = 4;
    localparam int unsigned IW   = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sched_en;
    logic [NR-1:0]     req_valid;
    logic [NR*4*DW-1:0] req_data;
    logic [NR-1:0]     req_ready;
    logic              avg_calc_en;
    logic [4*DW-1:0]   avg_imcin;
    logic [DW-1:0]     avg_imoy = '0;
    logic              out_valid;
    logic [IW-1:0]     out_id;
    logic [DW-1:0]     out_data;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    // Hand-computed rounded means of the default windows:
    //   r0 {1,2,3,4}         -> (10+2)>>2   = 3
    //   r1 {10,10,10,11}     -> (41+2)>>2   = 10
    //   r2 {100,200,300,400} -> (1000+2)>>2 = 250
    //   r3 {1,1,1,0}         -> (3+2)>>2    = 1
    int exp_avg [4] = '{3, 10, 250, 1};

    imoy_sched #(.DW_IN(DW), .NREQ(NR), .IDW(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sched_en   (sched_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .avg_calc_en(avg_calc_en),
        .avg_imcin  (avg_imcin),
        .avg_imoy   (avg_imoy),
        .out_valid  (out_valid),
        .out_id     (out_id),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // External averager model: result valid two cycles after its enable.
    logic [DW-1:0] avg_a = '0;
    always @(posedge clk) begin
        if (avg_calc_en)
            avg_a <= DW'((12'(avg_imcin[9:0]) + 12'(avg_imcin[19:10]) +
                          12'(avg_imcin[29:20]) + 12'(avg_imcin[39:30]) + 12'd2) >> 2);
        avg_imoy <= avg_a;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4*DW-1:0] win4(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic load_default_windows();
        req_data[0*40 +: 40] = win4(1, 2, 3, 4);
        req_data[1*40 +: 40] = win4(10, 10, 10, 11);
        req_data[2*40 +: 40] = win4(100, 200, 300, 400);
        req_data[3*40 +: 40] = win4(1, 1, 1, 0);
    endtask

    // Drive req_valid for this cycle and check the combinational grant.
    task automatic drive_chk(input string tag, input logic [NR-1:0] v, input logic [NR-1:0] expr);
        req_valid = v;
        #1;
        check(tag, req_ready, expr);
    endtask

    initial begin
        rst_n     = 1'b0;
        sched_en  = 1'b0;
        req_valid = '0;
        req_data  = '0;
        load_default_windows();

        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_id", out_id, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        rst_n    = 1'b1;
        sched_en = 1'b1;
        tick();

`ifdef IMOY_SCHED_PRIO0_EN
        // Requester 0 wins every cycle while valid, then 1 takes over.
        for (int c = 0; c < 4; c++) begin
            drive_chk("prio_r0", 4'b0011, 4'b0001);
            tick();
        end
        drive_chk("prio_r1", 4'b0010, 4'b0010);
        tick();
        drive_chk("prio_r0_again", 4'b1011, 4'b0001);
        tick();
        req_valid = '0;
        for (int c = 0; c < 6; c++) tick();
        check("prio_drain_busy", busy, 0);
`else
        // All four valid from pointer 0: grants 0,1,2,3,0; results at t+3.
        for (int c = 0; c < 9; c++) begin
            drive_chk("rr_ready", (c < 5) ? 4'hF : 4'h0,
                      (c < 5) ? NR'(4'b0001 << (c % 4)) : NR'(0));
            if (c >= 3 && c <= 7) begin
                check("rr_out_valid", out_valid, 1);
                check("rr_out_id", out_id, (c - 3) % 4);
                check("rr_out_data", out_data, exp_avg[(c - 3) % 4]);
            end else begin
                check("rr_out_idle", out_valid, 0);
            end
            check("rr_busy", busy, (c >= 1 && c <= 7) ? 1 : 0);
            tick();
        end
        check("rr_hold_id", out_id, 0);
        check("rr_hold_data", out_data, 3);

        // Requester 2 alone with a full-scale window (pointer is 1).
        req_data[2*40 +: 40] = {4{10'd1023}};
        for (int c = 0; c < 5; c++) begin
            drive_chk("max_ready", (c == 0) ? 4'b0100 : 4'b0000, (c == 0) ? 4'b0100 : 4'b0000);
            if (c == 0) begin
                check("max_calc_en", avg_calc_en, 1);
                check("max_imcin", avg_imcin, 40'hFF_FFFF_FFFF);
            end
            check("max_out_valid", out_valid, (c == 3) ? 1 : 0);
            if (c == 3) begin
                check("max_out_data", out_data, 1023);
                check("max_out_id", out_id, 2);
            end
            tick();
        end
        load_default_windows();

        // Pointer is 3: grant 1 moves it to 2, then {1,3} -> 3 then 1.
        drive_chk("wrap_set", 4'b0010, 4'b0010);
        tick();
        drive_chk("wrap_g3", 4'b1010, 4'b1000);
        tick();
        drive_chk("wrap_g1", 4'b1010, 4'b0010);
        tick();
        drive_chk("wrap_ptr2", 4'b1110, 4'b0100);
        check("wrap_out_id", out_id, 1);
        check("wrap_out_data", out_data, 10);
        req_valid = '0;
        for (int c = 0; c < 5; c++) tick();

        // Two transfers (2 then 3), then the scheduler is disabled.
        drive_chk("dis_g2", 4'hF, 4'b0100);
        tick();
        drive_chk("dis_g3", 4'hF, 4'b1000);
        tick();
        for (int c = 2; c < 6; c++) begin
            sched_en = 1'b0;
            drive_chk("dis_ready", 4'hF, 4'b0000);
            check("dis_calc_en", avg_calc_en, 0);
            check("dis_imcin", avg_imcin, 0);
            check("dis_busy", busy, (c <= 4) ? 1 : 0);
            check("dis_out_valid", out_valid, (c == 3 || c == 4) ? 1 : 0);
            if (c == 3) check("dis_out_id_a", out_id, 2);
            if (c == 3) check("dis_out_data_a", out_data, 250);
            if (c == 4) check("dis_out_id_b", out_id, 3);
            if (c == 4) check("dis_out_data_b", out_data, 1);
            tick();
        end
        req_valid = '0;
        sched_en  = 1'b1;

        // A transfer (moves the pointer to 3), then a reset pulse while in flight.
        drive_chk("rst_g2", 4'b0100, 4'b0100);
        tick();
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        check("arst_out_data", out_data, 0);
        check("arst_out_id", out_id, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("post_rst_valid", out_valid, 0);
            check("post_rst_busy", busy, 0);
            check("post_rst_data", out_data, 0);
            tick();
        end
        drive_chk("post_rst_ptr0", 4'hF, 4'b0001);
        req_valid = '0;
        tick();

        // A single requester that stays valid is granted every cycle.
        for (int c = 0; c < 7; c++) begin
            drive_chk("single_ready", (c < 3) ? 4'b0010 : 4'b0000, (c < 3) ? 4'b0010 : 4'b0000);
            check("single_out_valid", out_valid, (c >= 3 && c <= 5) ? 1 : 0);
            if (c >= 3 && c <= 5) begin
                check("single_out_id", out_id, 1);
                check("single_out_data", out_data, 10);
            end
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
